dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//   Requester-side load/store engine that drives the word-only, async-read/sync-write data memory.
//   Accepts one CPU load/store per handshake and issues the memory read/write cycles.
//   Implements RV32 LB/LH/LW/LBU/LHU/SB/SH/SW; sub-word stores use read-modify-write.
//   Sits between the CPU execute/mem stage and the data memory.
// PARAMETERS
//   MEM_DEPTH    16384  data memory depth in 32-bit words; byte addr >= MEM_DEPTH*4 -> error
//   CHECK_ALIGN  1      1: misaligned access -> error; 0: low addr bits cleared, access proceeds
// PORTS
//   clk          in   1   clock
//   reset        in   1   synchronous, active-high reset
//   req_valid    in   1   CPU request valid
//   req_ready    out  1   unit can accept (high only in IDLE)
//   req_write    in   1   1=store, 0=load
//   req_funct3   in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr     in   32  byte address
//   req_wdata    in   32  store data (lane 0 aligned, i.e. bits [7:0]/[15:0])
//   resp_valid   out  1   one-cycle completion pulse
//   resp_rdata   out  32  extended load result; 0 for stores and errors
//   resp_error   out  1   valid with resp_valid: misaligned, illegal funct3 or out of range
//   mem_addr     out  32  word address to memory, {addr[31:2],2'b00}
//   mem_din      out  32  write data to memory
//   mem_read     out  1   memory read strobe
//   mem_write    out  1   memory write strobe (memory writes on the next posedge)
//   mem_dout     in   32  async memory read data
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1 the cycle after reset deasserts; resp_valid=0, resp_rdata=0,
//     resp_error=0, mem_read=0, mem_write=0, mem_addr=0, mem_din=0.
//   mem_read/mem_write decode from the state register, gated by ~reset, so a write coinciding with reset is suppressed.
//   Accept: req_valid & req_ready at a posedge latches write, funct3, addr, wdata.
//   Error check at accept: funct3 in {011,110,111}; store funct3 not in {000,001,010};
//     CHECK_ALIGN=1 and (H/HU/SH addr[0]!=0 or W addr[1:0]!=0); addr >= MEM_DEPTH*4.
//   FSM:
//     IDLE   -> ERR on error; LOAD on load; STORE on SW; RMW_RD on SB/SH; else stay.
//     LOAD   : mem_read=1; capture lane-selected/extended mem_dout -> RESP.
//     RMW_RD : mem_read=1; capture mem_dout into merge reg -> STORE.
//     STORE  : mem_write=1; mem_din = wdata (SW) or merge reg with byte/half lane replaced -> RESP.
//     ERR    : no memory strobes -> RESP with error flag set.
//     RESP   : resp_valid=1 for exactly one cycle -> IDLE. resp_rdata/resp_error are held until the next resp_valid.
//   Latency, from accept edge to the cycle resp_valid is high: error 2, load 2, SW 2, SB/SH 3.
//   Throughput: next accept at the earliest on the RESP cycle edge, i.e. req_ready is high the cycle after RESP.
//   Lanes are little-endian: byte k = bits[8k+7:8k], k=addr[1:0]; half uses addr[1].
//   Extension: B/H sign-extend; BU/HU zero-extend; W passes through.
//   No memory strobe is ever asserted outside LOAD/RMW_RD/STORE.
//   mem_addr is driven only in those states, 0 otherwise.
//   Reset mid-operation returns to IDLE next cycle and discards the in-flight request with no resp_valid.
//   A pending SB/SH merge is dropped, and memory keeps its old word.
//   req_valid while busy is ignored; the requester must hold the request until req_ready.
// TESTING
//   1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> resp_rdata 0xDEADBEEF.
//      mem_write high 1 cycle; latencies 2/2.
//   2. After test 1: SB addr 0x11 data 0x55 -> word 0xDEAD55EF.
//      LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE.
//   3. SH addr 0x12 data 0x8001 -> word 0x800155EF.
//      LH 0x12 -> 0xFFFF8001; LHU 0x12 -> 0x00008001.
//   4. LW 0x12 and SH 0x11 with CHECK_ALIGN=1 -> resp_error=1, rdata 0, no mem strobes, memory unchanged.
//      funct3=011 -> error.
//   5. LW addr 0x10000 (MEM_DEPTH=16384) -> resp_error=1.
//   6. Reset in RMW_RD of SB 0x10 -> no resp_valid, no mem_write, word unchanged, req_ready=1 after reset.

Source files
------------

// File: rtl/dmem_access_unit.sv
// Load/store engine between the CPU mem stage and a word-wide, async-read/sync-write data memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended here.
module dmem_access_unit #(
    parameter int MEM_DEPTH   = 16384,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    // Handshake: a request transfers on a posedge where req_valid && req_ready; the
    // requester holds it stable until then. resp_valid is a single-cycle completion pulse.
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_STORE  = 3'd3,
        S_ERR    = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_DEPTH) * 34'd4;

    state_t      state, state_next;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_err;
    logic [31:0] req_addr_eff;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_value;
    logic [31:0] store_word;

    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    // Request decode: error classification and, when alignment is not enforced, address trimming.
    always_comb begin
        req_err      = 1'b0;
        req_addr_eff = req_addr;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
            req_err = 1'b1;
        if (req_write && req_funct3[2])
            req_err = 1'b1;
        if (CHECK_ALIGN) begin
            if (req_funct3[1:0] == 2'b01 && req_addr[0])
                req_err = 1'b1;
            if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
                req_err = 1'b1;
        end else begin
            if (req_funct3[1:0] == 2'b01)
                req_addr_eff[0] = 1'b0;
            if (req_funct3 == 3'b010)
                req_addr_eff[1:0] = 2'b00;
        end
        if ({2'b00, req_addr} >= ADDR_LIMIT)
            req_err = 1'b1;
    end

    always_comb begin
        lane_byte = mem_dout[{addr_q[1:0], 3'b000} +: 8];
        lane_half = mem_dout[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_value = {24'd0, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_value = {16'd0, lane_half};
            default: load_value = mem_dout;
        endcase
    end

    // SW writes wdata directly; SB/SH patch their lane into the word read in RMW_RD.
    always_comb begin
        store_word = merge_q;
        case (funct3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'd0;
        mem_din    = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready = ~reset;
                if (accept) begin
                    if (req_err)
                        state_next = S_ERR;
                    else if (!req_write)
                        state_next = S_LOAD;
                    else if (req_funct3 == 3'b010)
                        state_next = S_STORE;
                    else
                        state_next = S_RMW_RD;
                end
            end
            S_LOAD: begin
                mem_read   = ~reset;
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = S_RESP;
            end
            S_RMW_RD: begin
                mem_read   = ~reset;
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = S_STORE;
            end
            S_STORE: begin
                mem_write  = ~reset;
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_din    = store_word;
                state_next = S_RESP;
            end
            S_ERR: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = ~reset;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Response fields update on the edge into RESP and then hold until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            merge_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                addr_q   <= req_addr_eff;
                wdata_q  <= req_wdata;
            end
            case (state)
                S_LOAD: begin
                    resp_rdata <= load_value;
                    resp_error <= 1'b0;
                end
                S_RMW_RD: begin
                    merge_q <= mem_dout;
                end
                S_STORE: begin
                    resp_rdata <= 32'd0;
                    resp_error <= 1'b0;
                end
                S_ERR: begin
                    resp_rdata <= 32'd0;
                    resp_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed load/store/error cases, randomized traffic against a
// byte-lane memory model, back-to-back throughput and reset-abort behaviour.
module tb_dmem_access_unit;

    localparam int MEM_DEPTH = 16384;
    localparam int WIN       = 16;

    logic        clk, reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;
    logic [2:0]  dbg_state;

    logic [31:0] mem     [0:MEM_DEPTH-1];
    logic [31:0] ref_mem [0:MEM_DEPTH-1];
    logic        preload_en;
    logic [13:0] preload_idx;
    logic [31:0] preload_data;
    logic [31:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_access_unit #(.MEM_DEPTH(MEM_DEPTH), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read), .mem_write(mem_write),
        .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // data memory: async read, write on posedge
    assign mem_dout = mem[mem_addr[15:2]];
    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[15:2]] <= mem_din;
        else if (preload_en)
            mem[preload_idx] <= preload_data;
    end

    // reference model
    function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        e = 1'b0;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) e = 1'b1;
        if (w && f3 > 3'd2) e = 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2) != 0) e = 1'b1;
        if (f3 == 3'd2 && (a % 4) != 0) e = 1'b1;
        if (a >= 32'(MEM_DEPTH * 4)) e = 1'b1;
        return e;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] word, b, h;
        word = ref_mem[a[15:2]];
        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] word, mask;
        int sh;
        word = ref_mem[a[15:2]];
        if (f3 == 3'd0) begin
            sh = 8 * (a % 4);
            mask = 32'hFF << sh;
            word = (word & ~mask) | ((d & 32'hFF) << sh);
        end else if (f3 == 3'd1) begin
            sh = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            word = (word & ~mask) | ((d & 32'hFFFF) << sh);
        end else begin
            word = d;
        end
        ref_mem[a[15:2]] = word;
    endfunction

    // driver tasks (called at a negedge, return at a negedge)
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic preload_window();
        for (int i = 0; i < WIN; i++) begin
            preload_en = 1'b1;
            preload_idx = 14'(i);
            preload_data = $urandom;
            ref_mem[i] = preload_data;
            @(negedge clk);
        end
        preload_en = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output logic err, output int lat, output int nrd,
                         output int nwr, output logic pulse2, output logic rdy_after, output logic tmo,
                         output int waits);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        waits = 0; lat = 0; nrd = 0; nwr = 0; rdata = 32'd0; err = 1'b0;
        pulse2 = 1'b0; rdy_after = 1'b0; tmo = 1'b0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            tmo = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            nrd = nrd + int'(mem_read);
            nwr = nwr + int'(mem_write);
            @(negedge clk);
            lat++;
        end
        nrd = nrd + int'(mem_read);
        nwr = nwr + int'(mem_write);
        if (!resp_valid) tmo = 1'b1;
        rdata = resp_rdata;
        err = resp_error;
        @(negedge clk);
        pulse2 = resp_valid;
        rdy_after = req_ready;
    endtask

    // tests
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'd0 || resp_error !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %h/%b want 0/0", resp_rdata, resp_error); end
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got %b%b want 00", mem_read, mem_write); end
        n_checks++; if (mem_addr !== 32'd0 || mem_din !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_din); end
    endtask

    task automatic test_directed();
        logic [31:0] r; logic e, p2, ra, to; int lat, nrd, nwr, wt;
        logic [31:0] ops_addr [0:7];
        logic [31:0] ops_data [0:7];
        logic [2:0]  ops_f3   [0:7];
        logic        ops_w    [0:7];
        logic [31:0] exp_word [0:7];
        logic [31:0] exp_rd   [0:7];
        int          exp_lat  [0:7];
        // SW, LW, SB, LB, LBU, SH, LH, LHU on the word at 0x10
        ops_w    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ops_f3   = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd1, 3'd1, 3'd5};
        ops_addr = '{32'h10, 32'h10, 32'h11, 32'h13, 32'h13, 32'h12, 32'h12, 32'h12};
        ops_data = '{32'hDEADBEEF, 32'h0, 32'h55, 32'h0, 32'h0, 32'h8001, 32'h0, 32'h0};
        exp_rd   = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFDE, 32'h000000DE, 32'h0, 32'hFFFF8001, 32'h00008001};
        exp_word = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEAD55EF, 32'hDEAD55EF, 32'hDEAD55EF,
                     32'h800155EF, 32'h800155EF, 32'h800155EF};
        exp_lat  = '{2, 2, 3, 2, 2, 3, 2, 2};
        for (int i = 0; i < 8; i++) begin
            issue(ops_w[i], ops_f3[i], ops_addr[i], ops_data[i], r, e, lat, nrd, nwr, p2, ra, to, wt);
            if (ops_w[i]) model_store(ops_f3[i], ops_addr[i], ops_data[i]);
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL dir%0d_timeout: got %b want 0", i, to); end
            n_checks++; if (r !== exp_rd[i] || e !== 1'b0) begin n_fail++; $display("FAIL dir%0d_resp: got %h/%b want %h/0", i, r, e, exp_rd[i]); end
            n_checks++; if (lat != exp_lat[i]) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat[i]); end
            n_checks++; if (nwr != int'(ops_w[i])) begin n_fail++; $display("FAIL dir%0d_write_cycles: got %0d want %0d", i, nwr, int'(ops_w[i])); end
            n_checks++; if (mem[4] !== exp_word[i]) begin n_fail++; $display("FAIL dir%0d_mem_word: got %h want %h", i, mem[4], exp_word[i]); end
            n_checks++; if (p2 !== 1'b0 || ra !== 1'b1) begin n_fail++; $display("FAIL dir%0d_pulse_ready: got %b/%b want 0/1", i, p2, ra); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] r; logic e, p2, ra, to; int lat, nrd, nwr, wt;
        logic        ew [0:3];
        logic [2:0]  ef [0:3];
        logic [31:0] ea [0:3];
        // misaligned LW, misaligned SH, funct3 011, out-of-range LW
        ew = '{1'b0, 1'b1, 1'b0, 1'b0};
        ef = '{3'd2, 3'd1, 3'd3, 3'd2};
        ea = '{32'h12, 32'h11, 32'h10, 32'h0001_0000};
        for (int i = 0; i < 4; i++) begin
            issue(ew[i], ef[i], ea[i], 32'hA5A5_1234, r, e, lat, nrd, nwr, p2, ra, to, wt);
            n_checks++; if (e !== 1'b1 || r !== 32'd0) begin n_fail++; $display("FAIL err%0d_resp: got %h/%b want 0/1", i, r, e); end
            n_checks++; if (nrd != 0 || nwr != 0) begin n_fail++; $display("FAIL err%0d_strobes: got rd %0d wr %0d want 0 0", i, nrd, nwr); end
            n_checks++; if (lat != 2 || to !== 1'b0) begin n_fail++; $display("FAIL err%0d_latency: got %0d (timeout %b) want 2", i, lat, to); end
            n_checks++; if (mem[4] !== 32'h800155EF) begin n_fail++; $display("FAIL err%0d_mem_word: got %h want 800155ef", i, mem[4]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a, d, want; logic e, p2, ra, to, w, e_err; logic [2:0] f3;
        int lat, nrd, nwr, wt, e_lat, e_rd, e_wr;
        logic [2:0] load_f3 [0:4];
        load_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        preload_window();
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else f3 = load_f3[$urandom_range(0, 4)];
            if ($urandom_range(0, 11) == 0) a = 32'h0001_0000 + $urandom_range(0, 32'h7FFF_FFFF);
            else a = 32'($urandom_range(0, WIN * 4 - 1));
            d = $urandom;
            e_err = model_err(w, f3, a);
            e_lat = e_err ? 2 : ((w && f3 != 3'd2) ? 3 : 2);
            e_rd  = e_err ? 0 : ((!w || f3 != 3'd2) ? 1 : 0);
            e_wr  = (!e_err && w) ? 1 : 0;
            exp_q.push_back((e_err || w) ? 32'd0 : model_load(f3, a));
            if (!e_err && w) model_store(f3, a, d);
            issue(w, f3, a, d, r, e, lat, nrd, nwr, p2, ra, to, wt);
            want = exp_q.pop_front();
            n_checks++; if (r !== want || e !== e_err) begin n_fail++; $display("FAIL rnd%0d_resp w%b f3 %0d a %h: got %h/%b want %h/%b", n, w, f3, a, r, e, want, e_err); end
            n_checks++; if (lat != e_lat || to !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d (timeout %b) want %0d", n, lat, to, e_lat); end
            n_checks++; if (nrd != e_rd || nwr != e_wr) begin n_fail++; $display("FAIL rnd%0d_strobes: got rd %0d wr %0d want rd %0d wr %0d", n, nrd, nwr, e_rd, e_wr); end
            n_checks++; if (p2 !== 1'b0 || ra !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_pulse_ready: got %b/%b want 0/1", n, p2, ra); end
            if (e_wr == 1) begin
                n_checks++; if (mem[a[15:2]] !== ref_mem[a[15:2]]) begin n_fail++; $display("FAIL rnd%0d_mem_word: got %h want %h", n, mem[a[15:2]], ref_mem[a[15:2]]); end
            end
        end
        for (int i = 0; i < WIN; i++) begin
            n_checks++; if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL final_mem[%0d]: got %h want %h", i, mem[i], ref_mem[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, a, want; logic e, p2, ra, to; int lat, nrd, nwr, wt;
        for (int i = 0; i < 6; i++) begin
            a = 32'(4 * $urandom_range(0, WIN - 1));
            want = model_load(3'd2, a);
            issue(1'b0, 3'd2, a, 32'd0, r, e, lat, nrd, nwr, p2, ra, to, wt);
            n_checks++; if (wt != 0) begin n_fail++; $display("FAIL b2b%0d_accept_wait: got %0d want 0", i, wt); end
            n_checks++; if (r !== want || e !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_rdata: got %h/%b want %h/0", i, r, e, want); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] saved4, saved5, r; logic e, p2, ra, to; int wt, nresp, nwr, lat, nrd;
        // reset while SB 0x10 sits in its read phase
        saved4 = ref_mem[4];
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10; req_wdata = 32'h77;
        wt = 0;
        while (!req_ready && wt < 20) begin @(negedge clk); wt++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rmw_read_phase: got rd %b wr %b want 1 0", mem_read, mem_write); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rmw_abort_ready: got %b want 1", req_ready); end
        n_checks++; if (resp_rdata !== 32'd0 || resp_error !== 1'b0) begin n_fail++; $display("FAIL rmw_abort_resp: got %h/%b want 0/0", resp_rdata, resp_error); end
        nresp = 0; nwr = 0;
        repeat (5) begin
            nresp = nresp + int'(resp_valid);
            nwr = nwr + int'(mem_write);
            @(negedge clk);
        end
        n_checks++; if (nresp != 0 || nwr != 0) begin n_fail++; $display("FAIL rmw_abort_activity: got resp %0d wr %0d want 0 0", nresp, nwr); end
        n_checks++; if (mem[4] !== saved4) begin n_fail++; $display("FAIL rmw_abort_mem: got %h want %h", mem[4], saved4); end

        // reset arriving in the write cycle of SW 0x14 must suppress the write at once
        saved5 = ref_mem[5];
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h14; req_wdata = ~saved5;
        wt = 0;
        while (!req_ready && wt < 20) begin @(negedge clk); wt++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL sw_write_phase: got %b want 1", mem_write); end
        reset = 1'b1;
        #1;
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL sw_write_gated: got %b want 0", mem_write); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nresp = 0;
        repeat (4) begin
            nresp = nresp + int'(resp_valid);
            @(negedge clk);
        end
        n_checks++; if (nresp != 0) begin n_fail++; $display("FAIL sw_abort_resp: got %0d want 0", nresp); end
        n_checks++; if (mem[5] !== saved5) begin n_fail++; $display("FAIL sw_abort_mem: got %h want %h", mem[5], saved5); end

        // normal service resumes
        issue(1'b0, 3'd2, 32'h14, 32'd0, r, e, lat, nrd, nwr, p2, ra, to, wt);
        n_checks++; if (r !== saved5 || e !== 1'b0 || to !== 1'b0) begin n_fail++; $display("FAIL post_reset_load: got %h/%b want %h/0", r, e, saved5); end
    endtask

    initial begin
        preload_en = 1'b0; preload_idx = 14'd0; preload_data = 32'd0;
        do_reset();
        test_reset();
        test_directed();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
